fifo_wr_arb: RTL

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 30 +++
 rtl/fifo_wr_arb.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding and
// default sizing used by fifo_wr_arb and its round-robin selector.
package fifo_arb_pkg;

    localparam int NUM_REQ_DEF   = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int BURST_LEN_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        PAUSE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first requester at or after
// index ptr (wrapping) as a one-hot vector, or zero when nothing is requested.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter granting one requester at a time a burst of up to
// BURST_LEN beats into a shared FIFO write port, honouring FIFO backpressure.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic                      wr_clk,
    input  logic                      sys_rst_n,
    input  logic                      wr_rst_busy,
    input  logic                      almost_full,
    input  logic                      full,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic                      burst_done
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    // Reset asserts asynchronously but releases only after two wr_clk edges.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       arb_rst_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge wr_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rst_sync_q <= 2'b00;
        else            rst_sync_q <= rst_sync_d;
    end

    assign arb_rst_n = rst_sync_q[1];

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                done_q, done_d;

    logic [NUM_REQ-1:0]  winner;
    logic [PTR_W-1:0]    g_idx, ptr_adv;
    logic [DATA_W-1:0]   data_g;
    logic                req_g, stall, beat, release_burst, abort;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner)
    );

    always_comb begin
        g_idx  = '0;
        data_g = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                g_idx  = PTR_W'(i);
                data_g = req_data[i*DATA_W +: DATA_W];
            end
        end
        req_g   = |(req & grant_q);
        stall   = almost_full | full;
        beat    = (state_q == BURST) && req_g && !stall && !wr_rst_busy;
        ptr_adv = (g_idx == LAST_IDX) ? '0 : g_idx + PTR_W'(1);
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        beat_cnt_d    = beat_cnt_q;
        wr_en_d       = 1'b0;
        wr_data_d     = '0;
        done_d        = 1'b0;
        release_burst = 1'b0;
        abort         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!wr_rst_busy && !almost_full && (|req)) begin
                    grant_d = winner;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (wr_rst_busy)  abort         = 1'b1;
                else if (!req_g)  release_burst = 1'b1;
                else if (stall)   state_d       = PAUSE;
                else begin
                    wr_en_d   = 1'b1;
                    wr_data_d = data_g;
                    if (beat_cnt_q == LAST_BEAT) release_burst = 1'b1;
                    else                         beat_cnt_d    = beat_cnt_q + CNT_W'(1);
                end
            end
            PAUSE: begin
                if (wr_rst_busy)  abort         = 1'b1;
                else if (!req_g)  release_burst = 1'b1;
                else if (!stall)  state_d       = BURST;
            end
            default: state_d = IDLE;
        endcase

        // Abort behaves like a release except that it is not reported.
        if (release_burst || abort) begin
            state_d    = IDLE;
            grant_d    = '0;
            ptr_d      = ptr_adv;
            beat_cnt_d = '0;
            done_d     = release_burst;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge wr_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
        end
    end

    assign ack          = beat ? grant_q : '0;
    assign grant        = grant_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign burst_done   = done_q;

endmodule
